// File: rtl/multimode_counter_pkg.sv
// rtl/multimode_counter_pkg.sv - shared control and state encodings for the game counter
package multimode_counter_pkg;

   // Player step command as delivered by the input decoder
   typedef enum logic [1:0] {
      UP_S = 2'd0,
      UP_L = 2'd1,
      DN_S = 2'd2,
      DN_L = 2'd3
   } ctrl_e;

   // Match state: counting, one-cycle post-hit restart, match finished
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HIT  = 2'd1,
      OVER = 2'd2
   } state_e;

endpackage

// File: rtl/multimode_counter_game_score_tally.sv
// rtl/multimode_counter_game_score_tally.sv - saturating per-outcome score counter
module score_tally
#(
   parameter int SCORE_W     = 4,
   parameter int SCORE_LIMIT = 3
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               freeze,
   output logic [SCORE_W-1:0] score,
   output logic               at_limit
);

   localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(SCORE_LIMIT);

   logic [SCORE_W-1:0] score_q;
   logic [SCORE_W-1:0] score_d;

   // Next tally: bump on a hit unless frozen or already at the match limit
   always_comb begin
      score_d = score_q;
      if (inc && !freeze && (score_q != LIMIT)) begin
         score_d = score_q + 1'b1;
      end
   end

   // Tally register
   always_ff @(posedge clk) begin
      if (rst) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score    = score_q;
   assign at_limit = (score_q == LIMIT);

endmodule

// File: rtl/multimode_counter_game.sv
// rtl/multimode_counter_game.sv - clamping up/down game counter with win/lose match scoring
module multimode_counter_game
   import multimode_counter_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int WIN_VAL     = 2**WIDTH - 1,
   parameter int STEP_SMALL  = 1,
   parameter int STEP_LARGE  = 2,
   parameter int RESTART_VAL = 0,
   parameter int SCORE_W     = 4,
   parameter int SCORE_LIMIT = 3
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               init,
   input  logic [WIDTH-1:0]   init_val,
   input  logic [1:0]         control,
   output logic [WIDTH-1:0]   count,
   output logic               winner,
   output logic               loser,
   output logic [SCORE_W-1:0] win_score,
   output logic [SCORE_W-1:0] lose_score,
   output logic               game_over
);

   // Two bits of headroom: an up step from a count loaded at the top bound
   // must not wrap before the clamp comparison sees it.
   localparam int CALC_W = WIDTH + 2;

   localparam logic signed [CALC_W-1:0] WIN_C     = CALC_W'(WIN_VAL);
   localparam logic signed [CALC_W-1:0] STEP_S_C  = CALC_W'(STEP_SMALL);
   localparam logic signed [CALC_W-1:0] STEP_L_C  = CALC_W'(STEP_LARGE);
   localparam logic signed [CALC_W-1:0] ZERO_C    = '0;
   localparam logic [WIDTH-1:0]         WIN_W     = WIDTH'(WIN_VAL);
   localparam logic [WIDTH-1:0]         RESTART_W = WIDTH'(RESTART_VAL);
   localparam logic [SCORE_W-1:0]       LAST_HIT  = SCORE_W'(SCORE_LIMIT - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   count_q, count_d;
   logic               winner_q, winner_d;
   logic               loser_q, loser_d;
   logic               game_over_q, game_over_d;
   logic               win_inc, lose_inc;
   logic               win_at_limit, lose_at_limit;
   logic               score_freeze;
   logic [SCORE_W-1:0] win_score_w, lose_score_w;

   ctrl_e                    ctrl;
   logic                     step_up;
   logic signed [CALC_W-1:0] count_ext;
   logic signed [CALC_W-1:0] step_mag;
   logic signed [CALC_W-1:0] next_up;
   logic signed [CALC_W-1:0] next_dn;

   // Step arithmetic: decode command and form both candidate next values
   always_comb begin
      ctrl      = ctrl_e'(control);
      step_up   = (ctrl == UP_S) || (ctrl == UP_L);
      step_mag  = ((ctrl == UP_L) || (ctrl == DN_L)) ? STEP_L_C : STEP_S_C;
      count_ext = $signed({2'b00, count_q});
      next_up   = count_ext + step_mag;
      next_dn   = count_ext - step_mag;
   end

   // FSM next state: load, step with clamp, post-hit restart, frozen match end
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      winner_d    = 1'b0;
      loser_d     = 1'b0;
      game_over_d = game_over_q;
      win_inc     = 1'b0;
      lose_inc    = 1'b0;
      unique case (state_q)
         RUN: begin
            if (init) begin
               count_d = init_val;
            end else if (en) begin
               if (step_up) begin
                  if (next_up >= WIN_C) begin
                     count_d  = WIN_W;
                     winner_d = 1'b1;
                     win_inc  = 1'b1;
                     if (win_score_w == LAST_HIT) begin
                        state_d     = OVER;
                        game_over_d = 1'b1;
                     end else begin
                        state_d = HIT;
                     end
                  end else begin
                     count_d = next_up[WIDTH-1:0];
                  end
               end else begin
                  if (next_dn <= ZERO_C) begin
                     count_d  = '0;
                     loser_d  = 1'b1;
                     lose_inc = 1'b1;
                     if (lose_score_w == LAST_HIT) begin
                        state_d     = OVER;
                        game_over_d = 1'b1;
                     end else begin
                        state_d = HIT;
                     end
                  end else begin
                     count_d = next_dn[WIDTH-1:0];
                  end
               end
            end
         end
         HIT: begin
            count_d = init ? init_val : RESTART_W;
            state_d = RUN;
         end
         OVER: begin
            game_over_d = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         count_q     <= '0;
         winner_q    <= 1'b0;
         loser_q     <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         winner_q    <= winner_d;
         loser_q     <= loser_d;
         game_over_q <= game_over_d;
      end
   end

   assign score_freeze = (state_q == OVER) || win_at_limit || lose_at_limit;

   score_tally #(
      .SCORE_W     (SCORE_W),
      .SCORE_LIMIT (SCORE_LIMIT)
   ) u_win_tally (
      .clk      (clk),
      .rst      (rst),
      .inc      (win_inc),
      .freeze   (score_freeze),
      .score    (win_score_w),
      .at_limit (win_at_limit)
   );

   score_tally #(
      .SCORE_W     (SCORE_W),
      .SCORE_LIMIT (SCORE_LIMIT)
   ) u_lose_tally (
      .clk      (clk),
      .rst      (rst),
      .inc      (lose_inc),
      .freeze   (score_freeze),
      .score    (lose_score_w),
      .at_limit (lose_at_limit)
   );

   assign count      = count_q;
   assign winner     = winner_q;
   assign loser      = loser_q;
   assign win_score  = win_score_w;
   assign lose_score = lose_score_w;
   assign game_over  = game_over_q;

endmodule
